// File: rtl/m68k_pkg.sv
// Shared constants for the m68k bus-cycle sequencer: device classes and FSM state encoding.
package m68k_pkg;

  localparam logic [1:0] DEV_NONE   = 2'd0;
  localparam logic [1:0] DEV_EEPROM = 2'd1;
  localparam logic [1:0] DEV_RAM    = 2'd2;
  localparam logic [1:0] DEV_OTHER  = 2'd3;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_ACK  = 3'd2,
    ST_BERR = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // A cycle is requested when AS is low and at least one data strobe is low.
  function automatic logic start_req(input logic as_s, input logic uds_s, input logic lds_s);
    return !as_s && (!uds_s || !lds_s);
  endfunction

endpackage

// File: rtl/m68k_sync2.sv
// Two-flop synchroniser; RST_VAL sets the level held during reset (the inactive level).
module m68k_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/m68k_cycle_ctrl.sv
// 68000 bus-cycle sequencer: wait-state insertion, DTACK/BERR/OE generation.
// Optional macro BERR_WATCHDOG_EN enables the DEV_OTHER timeout to BERR.
module m68k_cycle_ctrl
  import m68k_pkg::*;
#(
  parameter int EEPROM_WS = 3,
  parameter int RAM_WS    = 1,
  parameter int TIMEOUT   = 255,
  parameter int CNT_W     = 8
) (
  input  logic            clk50,
  input  logic            reset,
  input  logic            as_n,
  input  logic            uds_n,
  input  logic            lds_n,
  input  logic            rw,
  input  logic [1:0]      dev_sel,
  input  logic            dtack_trig,
  output logic            dtack_n,
  output logic            berr_n,
  output logic            oe_n,
  output logic            busy,
  output logic [ST_W-1:0] dbg_state
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic w_as_s, w_uds_s, w_lds_s, w_rw_s, w_trig_s;

  m68k_sync2 #(.RST_VAL(1'b1)) u_sync_as   (.clk(clk50), .rst(reset), .d(as_n),       .q(w_as_s));
  m68k_sync2 #(.RST_VAL(1'b1)) u_sync_uds  (.clk(clk50), .rst(reset), .d(uds_n),      .q(w_uds_s));
  m68k_sync2 #(.RST_VAL(1'b1)) u_sync_lds  (.clk(clk50), .rst(reset), .d(lds_n),      .q(w_lds_s));
  m68k_sync2 #(.RST_VAL(1'b1)) u_sync_rw   (.clk(clk50), .rst(reset), .d(rw),         .q(w_rw_s));
  m68k_sync2 #(.RST_VAL(1'b0)) u_sync_trig (.clk(clk50), .rst(reset), .d(dtack_trig), .q(w_trig_s));

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [1:0]       r_dev, w_dev_nx;
  logic             r_rw, w_rw_nx;
  logic             r_dtack_n, r_berr_n, r_oe_n;
  logic             w_active;

  // Handshake: the CPU holds as_n low to request a cycle; dtack_n (or berr_n) low is the
  // response and stays low until as_n is seen high, after which one DONE clock separates
  // this cycle from the next request.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_dev_nx   = r_dev;
    w_rw_nx    = r_rw;
    case (r_state)
      ST_IDLE: begin
        if (start_req(w_as_s, w_uds_s, w_lds_s)) begin
          w_dev_nx   = dev_sel;
          w_rw_nx    = w_rw_s;
          w_state_nx = ST_WAIT;
          case (dev_sel)
            DEV_EEPROM: w_cnt_nx = CNT_W'(EEPROM_WS);
            DEV_RAM:    w_cnt_nx = CNT_W'(RAM_WS);
            DEV_OTHER:  w_cnt_nx = CNT_W'(TIMEOUT);
            default: begin
              w_cnt_nx   = '0;
              w_state_nx = ST_BERR;
            end
          endcase
        end
      end
      ST_WAIT: begin
        if (w_as_s) begin
          w_state_nx = ST_DONE;
        end else if (r_dev == DEV_OTHER) begin
          // Peripheral ready takes priority over the watchdog expiring on the same clock.
          if (w_trig_s) begin
            w_state_nx = ST_ACK;
          end else if (r_cnt != '0) begin
            w_cnt_nx = r_cnt - CNT_ONE;
          end
`ifdef BERR_WATCHDOG_EN
          else begin
            w_state_nx = ST_BERR;
          end
`endif
        end else if (r_cnt == '0) begin
          w_state_nx = ST_ACK;
        end else begin
          w_cnt_nx = r_cnt - CNT_ONE;
        end
      end
      ST_ACK, ST_BERR: begin
        if (w_as_s) w_state_nx = ST_DONE;
      end
      ST_DONE: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Nothing asserts on the start edge itself; outputs follow the next state from cycle 1 on.
  assign w_active = (r_state != ST_IDLE);

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_dev     <= DEV_NONE;
      r_rw      <= 1'b1;
      r_dtack_n <= 1'b1;
      r_berr_n  <= 1'b1;
      r_oe_n    <= 1'b1;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_dev     <= w_dev_nx;
      r_rw      <= w_rw_nx;
      r_dtack_n <= !(w_active && (w_state_nx == ST_ACK));
      r_berr_n  <= !(w_active && (w_state_nx == ST_BERR));
      r_oe_n    <= !(w_active && w_rw_nx &&
                     ((w_state_nx == ST_WAIT) || (w_state_nx == ST_ACK)));
    end
  end

  assign dtack_n   = r_dtack_n;
  assign berr_n    = r_berr_n;
  assign oe_n      = r_oe_n;
  assign busy      = w_active;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_m68k_cycle_ctrl.sv
// Directed bench for m68k_cycle_ctrl: output-change events scored against an expected queue.
module tb_m68k_cycle_ctrl;
  import m68k_pkg::*;

  logic            clk50 = 1'b0;
  logic            reset = 1'b1;
  logic            as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, rw = 1'b1, dtack_trig = 1'b0;
  logic [1:0]      dev_sel = 2'd0;
  logic            dtack_n, berr_n, oe_n, busy;
  logic [ST_W-1:0] dbg_state;

  m68k_cycle_ctrl dut (
    .clk50(clk50), .reset(reset), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n), .rw(rw),
    .dev_sel(dev_sel), .dtack_trig(dtack_trig), .dtack_n(dtack_n), .berr_n(berr_n),
    .oe_n(oe_n), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #10 clk50 = ~clk50;

  int cyc = 0;
  always @(posedge clk50) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  // Entry = {cycle count at which the change is first seen, {dtack_n, berr_n, oe_n, busy}}.
  logic [35:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        mon_en = 1'b0;
  logic [3:0]  prev = 4'b1110;

  task automatic push_ev(input int c, input logic [3:0] o);
    logic [31:0] cv;
    cv = c;
    exp_q.push_back({cv, o});
  endtask

  always @(negedge clk50) begin
    logic [3:0]  cur;
    logic [35:0] e;
    if (mon_en) begin
      cur = {dtack_n, berr_n, oe_n, busy};
      while (exp_q.size() > 0 && int'(exp_q[0][35:4]) < cyc) begin
        e = exp_q.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL missing_event: at cycle %0d outputs=%b, required change to %b at cycle %0d",
                 cyc, cur, e[3:0], e[35:4]);
      end
      if (cur !== prev) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event: cycle %0d outputs %b -> %b, no change required",
                   cyc, prev, cur);
        end else begin
          e = exp_q.pop_front();
          if (int'(e[35:4]) != cyc || e[3:0] !== cur) begin
            n_err++;
            $display("FAIL event: got %b at cycle %0d, required %b at cycle %0d",
                     cur, cyc, e[3:0], e[35:4]);
          end
        end
        prev = cur;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk50);
  endtask

  task automatic start_cyc(input logic [1:0] dev, input logic r, input logic use_lds,
                           output int c);
    c       = cyc;
    dev_sel = dev;
    rw      = r;
    if (use_lds) lds_n = 1'b0;
    else         uds_n = 1'b0;
    as_n    = 1'b0;
  endtask

  task automatic end_cyc();
    as_n  = 1'b1;
    uds_n = 1'b1;
    lds_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    repeat (3) @(negedge clk50);
    n_vec++;
    if ({dtack_n, berr_n, oe_n, busy} !== 4'b1110 || dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_state: outs=%b state=%0d, required outs=1110 state=%0d",
               {dtack_n, berr_n, oe_n, busy}, dbg_state, ST_IDLE);
    end
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk50);

    // RAM read, with a data-strobe release mid-cycle that must change nothing.
    start_cyc(DEV_RAM, 1'b1, 1'b0, c);
    push_ev(c + 3, 4'b1111);
    push_ev(c + 4, 4'b1101);
    push_ev(c + 5, 4'b0101);
    push_ev(c + 11, 4'b1111);
    push_ev(c + 12, 4'b1110);
    wait_to(c + 6);
    uds_n = 1'b1;
    wait_to(c + 8);
    end_cyc();
    wait_to(c + 16);

    // EEPROM write via LDS; dev_sel changes mid-cycle are ignored.
    start_cyc(DEV_EEPROM, 1'b0, 1'b1, c);
    push_ev(c + 3, 4'b1111);
    push_ev(c + 7, 4'b0111);
    push_ev(c + 13, 4'b1111);
    push_ev(c + 14, 4'b1110);
    wait_to(c + 5);
    dev_sel = DEV_NONE;
    wait_to(c + 10);
    end_cyc();
    wait_to(c + 18);

    // DEV_OTHER read acked by a 45 ns trigger pulse.
    start_cyc(DEV_OTHER, 1'b1, 1'b0, c);
    push_ev(c + 3, 4'b1111);
    push_ev(c + 4, 4'b1101);
    push_ev(c + 8, 4'b0101);
    push_ev(c + 15, 4'b1111);
    push_ev(c + 16, 4'b1110);
    wait_to(c + 5);
    dtack_trig = 1'b1;
    #45;
    dtack_trig = 1'b0;
    wait_to(c + 12);
    end_cyc();
    wait_to(c + 20);

    // DEV_OTHER write, never triggered.
    start_cyc(DEV_OTHER, 1'b0, 1'b0, c);
    push_ev(c + 3, 4'b1111);
`ifdef BERR_WATCHDOG_EN
    push_ev(c + 259, 4'b1011);
    push_ev(c + 268, 4'b1111);
    push_ev(c + 269, 4'b1110);
    wait_to(c + 265);
    end_cyc();
    wait_to(c + 273);
`else
    push_ev(c + 1007, 4'b1110);
    wait_to(c + 1003);
    end_cyc();
    wait_to(c + 1011);
`endif

    // Unmapped write goes straight to BERR.
    start_cyc(DEV_NONE, 1'b0, 1'b0, c);
    push_ev(c + 3, 4'b1111);
    push_ev(c + 4, 4'b1011);
    push_ev(c + 11, 4'b1111);
    push_ev(c + 12, 4'b1110);
    wait_to(c + 8);
    end_cyc();
    wait_to(c + 16);

    // Reset during an EEPROM read wait, then a normal RAM read.
    start_cyc(DEV_EEPROM, 1'b1, 1'b0, c);
    push_ev(c + 3, 4'b1111);
    push_ev(c + 4, 4'b1101);
    wait_to(c + 5);
    #2;
    reset = 1'b1;
    end_cyc();
    #1;
    n_vec++;
    if ({dtack_n, berr_n, oe_n, busy} !== 4'b1110) begin
      n_err++;
      $display("FAIL async_reset: outs=%b immediately after reset, required 1110",
               {dtack_n, berr_n, oe_n, busy});
    end
    push_ev(c + 6, 4'b1110);
    wait_to(c + 7);
    reset = 1'b0;
    wait_to(c + 10);
    start_cyc(DEV_RAM, 1'b1, 1'b1, c);
    push_ev(c + 3, 4'b1111);
    push_ev(c + 4, 4'b1101);
    push_ev(c + 5, 4'b0101);
    push_ev(c + 9, 4'b1111);
    push_ev(c + 10, 4'b1110);
    wait_to(c + 6);
    end_cyc();
    wait_to(c + 14);

    // ---------------- final report ----------------
    mon_en = 1'b0;
    while (exp_q.size() > 0) begin
      logic [35:0] e;
      e = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_event: end of run, required %b at cycle %0d, never seen",
               e[3:0], e[35:4]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
